// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state, op encoding and index-width helper for mem_responder
package mem_pkg;
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;
    typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
    function automatic int idx_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requesting channel at or above ptr, wrapping modulo NUM_CHANNELS
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int IW = idx_bits(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [IW-1:0]           ptr,
    output logic [IW-1:0]           grant,
    output logic                    any
);
    assign any = |req;
    always_comb begin
        grant = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (req[IW'((int'(ptr) + i) % NUM_CHANNELS)]) grant = IW'((int'(ptr) + i) % NUM_CHANNELS);
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-channel round-robin memory endpoint over a single-port word array with fixed latency
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready
);
    localparam int IW = idx_bits(NUM_CHANNELS);
    localparam int CW = $clog2(LATENCY + 1);
    logic                    state, state_next;
    logic [IW-1:0]           rr_ptr, grant, ch;
    logic [CW-1:0]           counter;
    op_t                     op;
    logic [ADDR_BITS-1:0]    addr;
    logic [DATA_BITS-1:0]    wdata;
    logic [DATA_BITS-1:0]    mem [2**ADDR_BITS];
    logic [NUM_CHANNELS-1:0] req, done_mask;
    logic                    any, done, take;

    rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arb (
        .req  (req),
        .ptr  (rr_ptr),
        .grant(grant),
        .any  (any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = take ? BUSY : done ? IDLE : state;
    end

    // the completing channel is masked so it cannot be re-granted on its own completion edge
    always_comb begin
        done = (state == BUSY) && (counter == '0);
        done_mask = done ? NUM_CHANNELS'(1) << ch : '0;
        req = (mem_read_valid | mem_write_valid) & ~mem_read_ready & ~mem_write_ready & ~done_mask;
        take = any && ((state == IDLE) || done);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            counter <= '0;
            ch <= '0;
            op <= OP_READ;
            addr <= '0;
            wdata <= '0;
            mem_read_ready <= '0;
            mem_write_ready <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) mem_read_data[i] <= '0;
        end else begin
            if (take) begin
                counter <= CW'(LATENCY - 1);
                ch <= grant;
                op <= mem_read_valid[grant] ? OP_READ : OP_WRITE;
                addr <= mem_read_valid[grant] ? mem_read_address[grant] : mem_write_address[grant];
                wdata <= mem_write_data[grant];
                rr_ptr <= (int'(grant) == NUM_CHANNELS - 1) ? '0 : grant + IW'(1);
            end else if (state == BUSY && counter != '0) begin
                counter <= counter - CW'(1);
            end
            mem_read_ready <= mem_read_ready & mem_read_valid;
            mem_write_ready <= mem_write_ready & mem_write_valid;
            if (done && op == OP_READ) begin
                mem_read_data[ch] <= mem[addr];
                if (mem_read_valid[ch]) mem_read_ready[ch] <= 1'b1;
            end
            if (done && op == OP_WRITE && mem_write_valid[ch]) mem_write_ready[ch] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && done && op == OP_WRITE) mem[addr] <= wdata;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-channel memory responder: the memory-side endpoint of the `mem_read_*`/`mem_write_*` valid/ready protocol that memory controllers drive. It serves NUM_CHANNELS independent controller channels from one single-ported word array, accepting one request at a time via round-robin arbitration. Each request completes after a fixed LATENCY. It is the synthesizable data/program memory model used under the GPU top level in simulation and on FPGA.

## Interface
- ADDR_BITS, 8, word address width; array depth 2**ADDR_BITS
- DATA_BITS, 16, word width
- NUM_CHANNELS, 4, independent controller channels (>=1)
- LATENCY, 2, cycles from request acceptance to ready (>=1)

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all control state immediately
- mem_read_valid  in  [NUM_CHANNELS-1:0]  per-channel read request, level, held until ready seen
- mem_read_address  in  [ADDR_BITS-1:0] x NUM_CHANNELS  read address
- mem_read_ready  out  [NUM_CHANNELS-1:0]  read complete; data valid while high
- mem_read_data  out  [DATA_BITS-1:0] x NUM_CHANNELS  per-channel read data register
- mem_write_valid  in  [NUM_CHANNELS-1:0]  per-channel write request, level
- mem_write_address  in  [ADDR_BITS-1:0] x NUM_CHANNELS  write address
- mem_write_data  in  [DATA_BITS-1:0] x NUM_CHANNELS  write data
- mem_write_ready  out  [NUM_CHANNELS-1:0]  write committed

## Operation
- FSM states: IDLE, BUSY.
- Channel c is eligible when (read_valid[c] | write_valid[c]) & ~read_ready[c] & ~write_ready[c].
- In IDLE with any eligible channel, grant the first eligible channel scanning from rr_ptr upward modulo NUM_CHANNELS.
  - On grant: latch channel, op, address and write data; load counter = LATENCY-1; go BUSY; rr_ptr <= grant+1 mod NUM_CHANNELS.
- Op selection: read wins if both read_valid and write_valid are high on the granted channel; the write stays pending.
- BUSY: counter decrements each cycle. At counter==0 the op completes:
  - read: read_data[ch] <= array[addr]
  - write: array[addr] <= data
  - then return to IDLE.
- Ready on completion: the matching ready[ch] <= 1 only if that channel's valid for the op is still high at completion. Otherwise the completion is dropped silently; a write still commits.
- Ready clear: ready[c] <= 0 on the first edge where the matching valid[c] is sampled low. read_data[c] holds its value until the channel's next read completes.
- Inputs changing during BUSY are ignored; the latched copies are used.
- Counter width is $clog2(LATENCY+1); no wrap.

## Timing
- Reset values:
  - all ready bits 0
  - all mem_read_data 0
  - FSM IDLE, rr_ptr 0, counter 0
- Array contents are not reset and persist across reset.
- Reset mid-BUSY: an uncommitted in-flight write is discarded and no ready is raised.
- Latency: request accepted at edge E; ready high after edge E+LATENCY; next grant is possible at edge E+LATENCY.
- Minimum valid-rise-to-ready is LATENCY+1 edges (one sample edge plus LATENCY).
- Ready deasserts exactly one edge after valid is sampled low, so ready may be high for one cycle with valid already low. Requesters must not rely on that cycle.
- Back-to-back: the same channel cannot be re-granted while its ready is high. This prevents double-service of a held request.
- Simultaneous requests: with rr_ptr=0 and channels 1 and 3 valid, channel 1 is served first, then channel 3.

## Structure
- Shared package mem_pkg:
  - FSM state localparams (IDLE=1'b0, BUSY=1'b1)
  - op encoding (OP_READ, OP_WRITE)
- Sub-module rr_arbiter (NUM_CHANNELS): combinational; inputs request vector and pointer; outputs grant index and any-grant.
- Array is a plain reg array inferred as single-port RAM; one access per cycle at completion only.

## Test plan
- Write then read, LATENCY=2:
  - ch0 writes 0xBEEF to addr 0x10 -> write_ready[0] rises 2 edges after acceptance.
  - ch0 then reads 0x10 -> read_data[0]=0xBEEF with read_ready[0].
- Round-robin: ch0–ch3 all read distinct preloaded addrs at once -> completions in order 0,1,2,3 at 2-cycle spacing; then ch2 and ch0 together -> ch0 first (rr_ptr=0 after wrap).
- Held valid: ch1 holds read_valid 5 cycles after ready -> exactly one access, ready stays high, ch1 not re-granted; valid drops -> ready low next edge.
- Abort: ch2 write of 0x1234 to 0x20, valid drops during BUSY -> write_ready[2] never rises; later read of 0x20 returns 0x1234.
- Read/write conflict: ch3 asserts both, read 0x20, write 0x5555 to 0x21 -> read served first; write served after read_valid drops.
- Async reset mid-BUSY write of 0xAAAA to 0x30 (prior value 0x0001) -> all ready 0, read_data 0 without a clock edge; subsequent read of 0x30 returns 0x0001.
